// File: rtl/led_fader.sv
// led_fader: turns the toggling blink level into a PWM LED drive that fades
// linearly up on a rising blink edge and down on a falling one.
// Optional build macro LED_FADER_GAMMA_EN selects a square-law duty curve;
// without it the duty equals the brightness level.
module led_fader #(
    parameter int PWM_BITS  = 8,
    parameter int STEP_DIV  = 1000,
    parameter int MAX_LEVEL = 255
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                blink,
    output logic                led_pwm,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]    STEP_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] MAX_L     = PWM_BITS'(MAX_LEVEL);
    localparam logic [PWM_BITS-1:0] LVL_ONE   = PWM_BITS'(1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RISE = 2'd1,
        S_ON   = 2'd2,
        S_FALL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [CNT_W-1:0]    step_q, step_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                blink_q;
    logic                primed_q;
    logic                led_pwm_q;
    logic                busy_q;
    logic                rise;
    logic                fall;
    logic                ramping;
    logic                tick;
    logic [PWM_BITS-1:0] duty;

    // The first sample after reset only primes blink_q, so a blink level held
    // through reset is not mistaken for an edge.
    assign rise    = primed_q &  blink & ~blink_q;
    assign fall    = primed_q & ~blink &  blink_q;
    assign ramping = (state_q == S_RISE) || (state_q == S_FALL);
    assign tick    = ramping && (step_q == STEP_LAST);

`ifdef LED_FADER_GAMMA_EN
    // Square-law curve: upper half of the full-width level*level product.
    function automatic logic [PWM_BITS-1:0] gamma_duty(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] prod;
        prod = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    assign duty = gamma_duty(level_q);
`else
    assign duty = level_q;
`endif

    // Next-state logic: an accepted edge always beats a same-cycle tick and
    // restarts the step divider with the level held.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        step_d  = '0;
        case (state_q)
            S_OFF: begin
                if (rise) state_d = S_RISE;
            end
            S_ON: begin
                if (fall) state_d = S_FALL;
            end
            S_RISE: begin
                if (fall) begin
                    state_d = S_FALL;
                end else if (tick) begin
                    if (level_q == MAX_L - LVL_ONE) begin
                        state_d = S_ON;
                        level_d = MAX_L;
                    end else begin
                        level_d = level_q + LVL_ONE;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_FALL: begin
                if (rise) begin
                    state_d = S_RISE;
                end else if (tick) begin
                    if (level_q == LVL_ONE) begin
                        state_d = S_OFF;
                        level_d = '0;
                    end else begin
                        level_d = level_q - LVL_ONE;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                state_d = S_OFF;
                level_d = '0;
            end
        endcase
    end

    // Ramp state, level, divider and edge-detect registers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q  <= S_OFF;
            level_q  <= '0;
            step_q   <= '0;
            blink_q  <= 1'b0;
            primed_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            step_q   <= step_d;
            blink_q  <= blink;
            primed_q <= 1'b1;
            busy_q   <= (state_d == S_RISE) || (state_d == S_FALL);
        end
    end

    // Free-running PWM counter and registered comparator output.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pwm_cnt_q <= '0;
            led_pwm_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            led_pwm_q <= (pwm_cnt_q < duty);
        end
    end

    assign led_pwm = led_pwm_q;
    assign level   = level_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: drives the fader with directed and random blink patterns and
// compares every cycle against a direction/phase reference model.
module tb_led_fader;

    localparam int STEP = 4;
    localparam int MAXL = 255;
    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic       blink = 1'b0;
    logic       blink2 = 1'b0;
    logic       led_pwm, busy, led2, busy2;
    logic [7:0] level, level2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_fader #(.PWM_BITS(8), .STEP_DIV(STEP), .MAX_LEVEL(MAXL)) dut (
        .clk(clk), .reset_(reset_), .blink(blink),
        .led_pwm(led_pwm), .level(level), .busy(busy)
    );

    led_fader #(.PWM_BITS(8), .STEP_DIV(1), .MAX_LEVEL(MAXB)) dut64 (
        .clk(clk), .reset_(reset_), .blink(blink2),
        .led_pwm(led2), .level(level2), .busy(busy2)
    );

    function automatic int duty_of(int l);
`ifdef LED_FADER_GAMMA_EN
        return (l * l) / 256;
`else
        return l;
`endif
    endfunction

    // Reference model: brightness moves in direction m_dir (+1, -1, 0 idle)
    // by one every STEP cycles of ramping; idle at 0 or MAXL.
    int   m_level, m_dir, m_phase, m_cnt;
    logic m_prev, m_prim, m_led;
    int   n_level, n_dir, n_phase, n_cnt;
    logic n_led;

    always_comb begin
        n_level = m_level;
        n_dir   = m_dir;
        n_phase = m_phase;
        n_cnt   = (m_cnt + 1) % 256;
        n_led   = (m_cnt < duty_of(m_level));
        if (m_prim && blink && !m_prev && m_dir != 1 && !(m_dir == 0 && m_level == MAXL)) begin
            n_dir = 1; n_phase = 0;
        end else if (m_prim && !blink && m_prev && m_dir != -1 && !(m_dir == 0 && m_level == 0)) begin
            n_dir = -1; n_phase = 0;
        end else if (m_dir != 0) begin
            if (m_phase == STEP - 1) begin
                n_phase = 0;
                n_level = m_level + m_dir;
                if (n_level == 0 || n_level == MAXL) n_dir = 0;
            end else begin
                n_phase = m_phase + 1;
            end
        end
    end

    always @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            m_level <= 0; m_dir <= 0; m_phase <= 0; m_cnt <= 0;
            m_prev <= 1'b0; m_prim <= 1'b0; m_led <= 1'b0;
        end else begin
            m_level <= n_level; m_dir <= n_dir; m_phase <= n_phase; m_cnt <= n_cnt;
            m_prev <= blink; m_prim <= 1'b1; m_led <= n_led;
        end
    end

    task automatic test_reset();
        reset_ = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_assert++;
            if ({level, busy, led_pwm} !== 10'h0) begin
                n_fail++;
                $display("FAIL reset_hold: level=%0d busy=%0b led=%0b, required 0/0/0", level, busy, led_pwm);
            end
            blink = ~blink;
        end
        blink = 1'b0;
        @(negedge clk);
        reset_ = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            n_assert++;
            if ({level, busy, led_pwm} !== 10'h0) begin
                n_fail++;
                $display("FAIL reset_idle: cyc %0d level=%0d busy=%0b led=%0b, required 0/0/0", i, level, busy, led_pwm);
            end
        end
    endtask

    task automatic test_full_rise();
        int nb, hi;
        for (int dir = 1; dir >= 0; dir--) begin
            @(negedge clk);
            blink = dir[0];
            nb = 0;
            hi = 0;
            for (int i = 0; i < 1100; i++) begin
                @(negedge clk);
                if (busy) nb++;
                if (i >= 1030 && i < 1030 + 256 - 186 + 186 && i < 1100) hi += led_pwm;
                n_assert++;
                if ({level, busy, led_pwm} !== {8'(m_level), (m_dir != 0), m_led}) begin
                    n_fail++;
                    $display("FAIL ramp_%0d cyc %0d: level=%0d busy=%0b led=%0b, required %0d/%0b/%0b",
                             dir, i, level, busy, led_pwm, m_level, (m_dir != 0), m_led);
                end
            end
            n_assert++;
            if (nb != 1020) begin
                n_fail++;
                $display("FAIL ramp_time_%0d: busy cycles=%0d, required 1020", dir, nb);
            end
            n_assert++;
            if (level !== (dir ? 8'd255 : 8'd0) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL ramp_end_%0d: level=%0d busy=%0b, required %0d/0", dir, level, busy, dir ? 255 : 0);
            end
            hi = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clk);
                hi += int'(led_pwm);
            end
            n_assert++;
            if (hi != duty_of(dir ? 255 : 0)) begin
                n_fail++;
                $display("FAIL pwm_count_%0d: high=%0d, required %0d", dir, hi, duty_of(dir ? 255 : 0));
            end
        end
    endtask

    task automatic test_reversal();
        int k, nb;
        int lv;
        @(negedge clk);
        blink = 1'b1;
        k = 0;
        while (!(m_level == 100 && m_phase == STEP - 1 && m_dir == 1) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (k >= 2000) begin
            n_fail++;
            $display("FAIL rev_wait100: timeout level=%0d, required 100", level);
        end
        blink = 1'b0;
        nb = 0;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (i == 3 || i == 4) begin
                lv = (i == 3) ? 100 : 99;
                n_assert++;
                if (level !== 8'(lv)) begin
                    n_fail++;
                    $display("FAIL rev_hold cyc %0d: level=%0d, required %0d", i, level, lv);
                end
            end
            n_assert++;
            if ({level, busy, led_pwm} !== {8'(m_level), (m_dir != 0), m_led}) begin
                n_fail++;
                $display("FAIL rev_down cyc %0d: level=%0d busy=%0b led=%0b, required %0d/%0b/%0b",
                         i, level, busy, led_pwm, m_level, (m_dir != 0), m_led);
            end
        end
        n_assert++;
        if (nb != 400 || level !== 8'd0) begin
            n_fail++;
            $display("FAIL rev_fall_time: busy cycles=%0d level=%0d, required 400/0", nb, level);
        end
        blink = 1'b1;
        k = 0;
        while (!(m_level == 50) && k < 400) begin
            @(negedge clk);
            k++;
        end
        blink = 1'b0;
        while (!(m_level == 30 && m_dir == -1) && k < 800) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (k >= 800) begin
            n_fail++;
            $display("FAIL rev_wait30: timeout level=%0d, required 30", level);
        end
        blink = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_assert++;
            if ({level, busy, led_pwm} !== {8'(m_level), (m_dir != 0), m_led}) begin
                n_fail++;
                $display("FAIL rev_up cyc %0d: level=%0d busy=%0b led=%0b, required %0d/%0b/%0b",
                         i, level, busy, led_pwm, m_level, (m_dir != 0), m_led);
            end
        end
        n_assert++;
        if (level !== 8'd79 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rev_up_level: level=%0d busy=%0b, required 79/1", level, busy);
        end
    endtask

    task automatic test_pwm_linear();
        int hi, runs, k;
        logic prev;
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            hi += int'(led2);
        end
        n_assert++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL pwm_zero: high=%0d, required 0", hi);
        end
        blink2 = 1'b1;
        k = 0;
        while (!(level2 == 8'(MAXB) && busy2 == 1'b0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL pwm_ramp64: timeout level=%0d busy=%0b, required 64/0", level2, busy2);
        end
        @(negedge clk);
        prev = led2;
        hi = 0;
        runs = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            hi += int'(led2);
            if (led2 && !prev) runs++;
            prev = led2;
        end
        n_assert++;
        if (hi != 2 * duty_of(MAXB)) begin
            n_fail++;
            $display("FAIL pwm_duty64: high=%0d, required %0d", hi, 2 * duty_of(MAXB));
        end
        n_assert++;
        if (runs != 2) begin
            n_fail++;
            $display("FAIL pwm_contig: runs=%0d, required 2", runs);
        end
    endtask

    task automatic test_reset_mid_ramp();
        int k;
        @(negedge clk);
        blink = 1'b0;
        k = 0;
        while (!(m_dir == 0 && m_level == 0) && k < 1200) begin
            @(negedge clk);
            k++;
        end
        blink = 1'b1;
        while (!(m_level == 77) && k < 2600) begin
            @(negedge clk);
            k++;
        end
        n_assert++;
        if (k >= 2600 || level !== 8'd77) begin
            n_fail++;
            $display("FAIL mid_wait77: level=%0d, required 77", level);
        end
        @(posedge clk);
        #2 reset_ = 1'b0;
        #1;
        n_assert++;
        if ({level, busy, led_pwm} !== 10'h0) begin
            n_fail++;
            $display("FAIL mid_async: level=%0d busy=%0b led=%0b, required 0/0/0", level, busy, led_pwm);
        end
        @(negedge clk);
        reset_ = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            n_assert++;
            if ({level, busy, led_pwm} !== 10'h0) begin
                n_fail++;
                $display("FAIL mid_held: cyc %0d level=%0d busy=%0b led=%0b, required 0/0/0", i, level, busy, led_pwm);
            end
        end
        blink = 1'b0;
        @(negedge clk);
        blink = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_assert++;
            if ({level, busy, led_pwm} !== {8'(m_level), (m_dir != 0), m_led}) begin
                n_fail++;
                $display("FAIL mid_restart cyc %0d: level=%0d busy=%0b led=%0b, required %0d/%0b/%0b",
                         i, level, busy, led_pwm, m_level, (m_dir != 0), m_led);
            end
        end
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_restart_busy: busy=%0b, required 1", busy);
        end
    endtask

    task automatic test_random();
        int gap;
        gap = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            n_assert++;
            if ({level, busy, led_pwm} !== {8'(m_level), (m_dir != 0), m_led}) begin
                n_fail++;
                $display("FAIL random cyc %0d: level=%0d busy=%0b led=%0b, required %0d/%0b/%0b",
                         i, level, busy, led_pwm, m_level, (m_dir != 0), m_led);
            end
            gap--;
            if (gap == 0) begin
                blink = ~blink;
                gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(900, 1100))
                                                  : int'($urandom_range(1, 80));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_rise();
        test_reversal();
        test_pwm_linear();
        test_reset_mid_ramp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
